// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the shared shift-add multiplier scheduler.
package mult_sched_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MULT_WIDTH = 8;

  // Bits needed to count WIDTH shift steps (at least one bit).
  function automatic int step_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int STEP_CNT_W = step_cnt_w(MULT_WIDTH);

  // Sequencer states, in the order one multiply walks through them.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    EVAL,
    SHIFT,
    CAPTURE,
    RESP
  } state_e;

  // Index of a requester (two clients).
  typedef logic owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, registered "last served".
module rr_arb2
  import mult_sched_pkg::*;
#(
  parameter bit LAST_INIT = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  owner_t     owner_i,
  output owner_t     win_o
);

  owner_t last_q;

  // Remember who was served last so a tie goes to the other requester.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= owner_t'(LAST_INIT);
    end else if (update_i) begin
      last_q <= owner_i;
    end
  end

  // A sole requester wins outright; on a tie the one not served last wins.
  always_comb begin
    win_o = 1'b0;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = ~last_q;
      default: win_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one external shift-add signed multiplier datapath between two
// requesters: arbitrates, latches operands and sequences load/clear/add/sub/
// shift, then returns the product with a per-requester done pulse.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH     = MULT_WIDTH,
  parameter bit LAST_INIT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [1:0]           req_i,
  input  logic [WIDTH-1:0]     mcand0_i,
  input  logic [WIDTH-1:0]     mplier0_i,
  input  logic [WIDTH-1:0]     mcand1_i,
  input  logic [WIDTH-1:0]     mplier1_i,
  input  logic                 m_i,
  input  logic [2*WIDTH:0]     xab_i,
  output logic [WIDTH-1:0]     operand_o,
  output logic                 load_o,
  output logic                 clear_ax_o,
  output logic                 add_o,
  output logic                 sub_o,
  output logic                 shift_o,
  output logic [1:0]           gnt_o,
  output logic [1:0]           done_o,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int CNT_W = step_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q;
  owner_t             owner_q;
  logic [1:0]         gnt_q;
  logic [1:0]         done_q;
  logic               load_q;
  logic               clear_ax_q;
  logic               add_en_q;
  logic               sub_en_q;
  logic               shift_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] product_q;

  owner_t             win;
  logic               arb_update;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   sel_mcand;
  logic [WIDTH-1:0]   sel_mplier;
  logic               unused_x_bit;

  // The X sign bit never reaches the product; only {A,B} is captured.
  assign unused_x_bit = xab_i[2*WIDTH];

  assign arb_update = (state_q == RESP);
  assign cnt_inc    = cnt_q + 1'b1;

  rr_arb2 #(
    .LAST_INIT (LAST_INIT)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .update_i  (arb_update),
    .owner_i   (owner_q),
    .win_o     (win)
  );

  // Operand mux in front of the latches, steered by the arbiter winner.
  always_comb begin
    sel_mcand  = mcand0_i;
    sel_mplier = mplier0_i;
    if (win == 1'b1) begin
      sel_mcand  = mcand1_i;
      sel_mplier = mplier1_i;
    end
  end

  // Sequencer: computes next state and the outputs that belong to it, so
  // every control except add/sub leaves the block straight from a flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      load_q     <= 1'b0;
      clear_ax_q <= 1'b0;
      add_en_q   <= 1'b0;
      sub_en_q   <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      operand_q  <= '0;
      product_q  <= '0;
    end else begin
      // Single-cycle strobes fall back to zero unless a state asks for them.
      load_q     <= 1'b0;
      clear_ax_q <= 1'b0;
      add_en_q   <= 1'b0;
      sub_en_q   <= 1'b0;
      shift_q    <= 1'b0;
      done_q     <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            owner_q   <= win;
            gnt_q     <= (win == 1'b1) ? 2'b10 : 2'b01;
            mcand_q   <= sel_mcand;
            mplier_q  <= sel_mplier;
            operand_q <= sel_mplier;
            load_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          operand_q  <= mcand_q;
          clear_ax_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= CLEAR;
        end
        CLEAR: begin
          add_en_q <= (LAST_STEP != '0);
          sub_en_q <= (LAST_STEP == '0);
          state_q  <= EVAL;
        end
        EVAL: begin
          shift_q <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_inc;
          if (cnt_q == LAST_STEP) begin
            state_q <= CAPTURE;
          end else begin
            // The sign bit of the multiplier carries negative weight.
            add_en_q <= (cnt_inc != LAST_STEP);
            sub_en_q <= (cnt_inc == LAST_STEP);
            state_q  <= EVAL;
          end
        end
        CAPTURE: begin
          product_q <= xab_i[2*WIDTH-1:0];
          done_q    <= (owner_q == 1'b1) ? 2'b10 : 2'b01;
          state_q   <= RESP;
        end
        RESP: begin
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // M is the live B[0] after the preceding shift, so add/sub gate on it
  // combinationally; the step-dependent enable is registered.
  assign add_o      = add_en_q & m_i;
  assign sub_o      = sub_en_q & m_i;
  assign load_o     = load_q;
  assign clear_ax_o = clear_ax_q;
  assign shift_o    = shift_q;
  assign operand_o  = operand_q;
  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign product_o  = product_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench: mult_scheduler driving a 17-bit X:A:B register with a
// 9-bit add/sub adder; expected values are hand-computed constants.
module tb_mult_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [7:0]  mcand0 = 8'd0, mplier0 = 8'd0, mcand1 = 8'd0, mplier1 = 8'd0;
  logic [16:0] xab = 17'd0;
  logic [7:0]  operand;
  logic        load, clear_ax, add, sub, shift, busy;
  logic [1:0]  gnt, done;
  logic [15:0] product;
  logic [8:0]  sum;
  logic [4:0]  ctl;
  logic [4:0]  exp_ctl [20];

  int checks = 0;
  int errors = 0;
  int lat;
  logic [1:0] d;

  always #5 clk = ~clk;

  mult_scheduler dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .req_i      (req),
    .mcand0_i   (mcand0),
    .mplier0_i  (mplier0),
    .mcand1_i   (mcand1),
    .mplier1_i  (mplier1),
    .m_i        (xab[0]),
    .xab_i      (xab),
    .operand_o  (operand),
    .load_o     (load),
    .clear_ax_o (clear_ax),
    .add_o      (add),
    .sub_o      (sub),
    .shift_o    (shift),
    .gnt_o      (gnt),
    .done_o     (done),
    .product_o  (product),
    .busy_o     (busy)
  );

  // Datapath: X is xab[16], A is xab[15:8], B is xab[7:0].
  always_comb begin
    if (sub) sum = {xab[15], xab[15:8]} - {operand[7], operand};
    else     sum = {xab[15], xab[15:8]} + {operand[7], operand};
  end
  assign ctl = {load, clear_ax, add, sub, shift};

  always @(posedge clk) begin
    if (load)            xab <= {9'd0, operand};
    else if (clear_ax)   xab <= {9'd0, xab[7:0]};
    else if (add || sub) xab <= {sum, xab[7:0]};
    else if (shift)      xab <= {xab[16], xab[16:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles from 'start' until any done pulse, bounded.
  task automatic wait_done_from(input int start, output int n, output logic [1:0] dv);
    n  = start;
    dv = 2'b00;
    for (int i = 0; i < 60; i++) begin
      step();
      n++;
      if (done !== 2'b00) begin
        dv = done;
        break;
      end
    end
    if (dv == 2'b00) n = 999;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    exp_ctl = '{5'b10000, 5'b01000, 5'b00100, 5'b00001, 5'b00000,
                5'b00001, 5'b00100, 5'b00001, 5'b00100, 5'b00001,
                5'b00100, 5'b00001, 5'b00100, 5'b00001, 5'b00100,
                5'b00001, 5'b00010, 5'b00001, 5'b00000, 5'b00000};

    // Reset state
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ctl", 32'(ctl), 32'h0);
    check("rst_product", 32'(product), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_operand", 32'(operand), 32'h0);
    reset_n = 1'b1;
    step();

    // Single multiply 7 * -3 with exact control sequence
    mcand0 = 8'd7; mplier0 = 8'hFD; req = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      step();
      check($sformatf("ctl_c%0d", c), 32'(ctl), 32'(exp_ctl[c-1]));
      if (c == 1) begin
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_busy", 32'(busy), 32'h1);
      end
    end
    check("single_done", 32'(done), 32'h1);
    check("single_product", 32'(product), 32'hFFEB);
    $display("op single 7*-3 product=%h done=%b", product, done);
    req = 2'b00;
    step();
    check("single_done_pulse", 32'(done), 32'h0);
    check("single_gnt_idle", 32'(gnt), 32'h0);
    check("single_busy_idle", 32'(busy), 32'h0);
    check("single_product_held", 32'(product), 32'hFFEB);

    // Tie after reset: requester 0 first, then requester 1 after one IDLE
    do_reset();
    mcand0 = 8'd3; mplier0 = 8'd5; mcand1 = 8'hFC; mplier1 = 8'd6; req = 2'b11;
    wait_done_from(0, lat, d);
    check("tie_first_done", 32'(d), 32'h1);
    check("tie_first_lat", 32'(lat), 32'd20);
    check("tie_first_gnt", 32'(gnt), 32'h1);
    check("tie_first_product", 32'(product), 32'h000F);
    $display("op tie 3*5 product=%h lat=%0d", product, lat);
    req = 2'b10;
    wait_done_from(0, lat, d);
    check("tie_second_done", 32'(d), 32'h2);
    check("tie_second_lat", 32'(lat), 32'd21);
    check("tie_second_product", 32'(product), 32'hFFE8);
    $display("op tie -4*6 product=%h lat=%0d", product, lat);
    req = 2'b00;
    step(); step();

    // Round-robin with both requests held for four operations
    mcand0 = 8'd2; mplier0 = 8'd3; mcand1 = 8'd5; mplier1 = 8'hFF; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done_from(0, lat, d);
      check($sformatf("rr%0d_done", k), 32'(d), (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_lat", k), 32'(lat), (k == 0) ? 32'd20 : 32'd21);
      check($sformatf("rr%0d_product", k), 32'(product), (k % 2 == 0) ? 32'h0006 : 32'hFFFB);
      $display("op rr%0d done=%b product=%h lat=%0d", k, d, product, lat);
    end
    req = 2'b00;
    step(); step();

    // Extreme operands on requester 0
    begin
      logic [7:0]  ext_a [4];
      logic [7:0]  ext_b [4];
      logic [15:0] ext_p [4];
      ext_a = '{8'h80, 8'h80, 8'h00, 8'hFF};
      ext_b = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
      ext_p = '{16'h4000, 16'hC080, 16'h0000, 16'h0001};
      for (int k = 0; k < 4; k++) begin
        mcand0 = ext_a[k]; mplier0 = ext_b[k]; req = 2'b01;
        wait_done_from(0, lat, d);
        check($sformatf("ext%0d_done", k), 32'(d), 32'h1);
        check($sformatf("ext%0d_product", k), 32'(product), 32'(ext_p[k]));
        $display("op ext %h*%h product=%h", ext_a[k], ext_b[k], product);
        req = 2'b00;
        step(); step();
      end
    end

    // Reset during the fourth SHIFT
    mcand0 = 8'd9; mplier0 = 8'd9; req = 2'b01;
    for (int c = 1; c <= 10; c++) step();
    check("midrst_shift_seen", 32'(shift), 32'h1);
    reset_n = 1'b0;
    req = 2'b00;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_ctl", 32'(ctl), 32'h0);
    check("midrst_product", 32'(product), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    $display("op midrst gnt=%b product=%h", gnt, product);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    req = 2'b01;
    wait_done_from(0, lat, d);
    check("after_rst_done", 32'(d), 32'h1);
    check("after_rst_lat", 32'(lat), 32'd20);
    check("after_rst_product", 32'(product), 32'h0051);
    $display("op after-reset 9*9 product=%h lat=%0d", product, lat);
    req = 2'b00;
    step(); step();

    // Operands and req change in cycle 5; latched values must be used
    mcand0 = 8'd6; mplier0 = 8'hF9; req = 2'b01;
    for (int c = 1; c <= 5; c++) step();
    mcand0 = 8'd100; mplier0 = 8'd1; req = 2'b00;
    wait_done_from(5, lat, d);
    check("stab_done", 32'(d), 32'h1);
    check("stab_lat", 32'(lat), 32'd20);
    check("stab_product", 32'(product), 32'hFFD6);
    $display("op stability 6*-7 product=%h lat=%0d", product, lat);
    step(); step();
    check("stab_idle_busy", 32'(busy), 32'h0);
    check("stab_product_held", 32'(product), 32'hFFD6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
